csa_pipe_adder: RTL and testbench
=================================

// Module: csa_pipe_adder
// PURPOSE
// - Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 4-bit carry-select adder.
// - Operand width is split into NBLK = WIDTH/BLOCK carry-select blocks, with one register stage per block.
// - Streams one operation per cycle through a valid/ready handshake, with full backpressure.
// - Adds a subtract mode and a signed-overflow flag.
// PARAMETERS
// - WIDTH  16  operand/result width; must be a multiple of BLOCK (elaboration $error otherwise).
// - BLOCK   4  bits per carry-select block = bits resolved per pipeline stage.
// PORTS
// - clk        in   1      clock; all state on rising edge.
// - rst        in   1      synchronous, active-high reset.
// - in_valid   in   1      operation offered.
// - in_ready   out  1      block accepts the operation this cycle.
// - in_a       in   WIDTH  operand A.
// - in_b       in   WIDTH  operand B.
// - in_cin     in   1      carry-in (borrow-in when in_sub=1).
// - in_sub     in   1      0: A+B+cin; 1: A-B-cin.
// - out_valid  out  1      result valid.
// - out_ready  in   1      downstream accepts the result.
// - out_sum    out  WIDTH  result, modulo 2^WIDTH.
// - out_cout   out  1      carry out of the MSB; for subtract, 1 means no borrow.
// - out_ovf    out  1      two's-complement overflow = carry into MSB XOR carry out of MSB.
// BEHAVIOUR
// - Handshake
//   - Transfer in when in_valid & in_ready.
//   - Transfer out when out_valid & out_ready.
// - Operand preparation
//   - Effective B = in_sub ? ~in_b : in_b.
//   - Effective carry-in = in_cin ^ in_sub.
// - Pipeline stage k (0..NBLK-1)
//   - Computes bits [k*BLOCK +: BLOCK] twice: once with carry 0, once with carry 1.
//   - Selects between the two using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
//   - Registers the selected sum slice and the block carry.
//   - Forwards the not-yet-added upper operand bits (skew registers).
//   - Forwards the lower result slices (deskew registers).
// - Latency: exactly NBLK cycles from input transfer to out_valid, with no stall. NBLK=4 for the defaults.
// - Throughput: 1 op/cycle.
// - Stall (pipeline advance enable)
//   - adv = ~out_valid | out_ready. The whole pipe advances only when adv=1; in_ready = adv.
//   - While adv=0, every stage register and every output holds bit-stable.
//   - Bubbles are not compressed (simple global stall).
// - Stage valid bits shift with adv.
//   - out_valid = valid bit of the last stage.
//   - Results leave in strict input order, with no loss and no duplication.
// - Simultaneous in and out transfer in the same cycle is legal and is the normal streaming case.
// - in_valid=0 while adv=1 inserts a bubble (valid 0). Data registers may update and are don't-care.
// - Reset
//   - All valid bits clear; out_valid=0; out_sum=0; out_cout=0; out_ovf=0.
//   - in_ready=1 the cycle after reset deasserts (in_ready is combinational from out_valid and out_ready).
// - Reset mid-operation: all in-flight operations are discarded. No out_valid is produced for them.
// - Wrap-around: sum wraps modulo 2^WIDTH; out_cout reports the lost carry.
// - Full carry ripple across all blocks (e.g. 0xFFFF+1) still completes in NBLK cycles.
// STRUCTURE
// - Package csa_pkg: default WIDTH/BLOCK localparams and an NBLK helper function (WIDTH/BLOCK).
// - One sub-module, csa_block (combinational, BLOCK bits).
//   - Inputs: a, b, cin.
//   - Outputs: sum, cout, and c_msb (carry into the block MSB, needed for ovf in the top block).
//   - Internally: two ripple adders (carry 0 and carry 1), output selected by cin.
// - Top level: generate loop of NBLK csa_block instances, plus stage/skew/deskew registers and the valid shift chain.
// TESTING (WIDTH=16, BLOCK=4, latency 4)
// - Reset: hold rst 2 cycles -> out_valid=0, out_sum=0x0000, out_cout=0, out_ovf=0, in_ready=1.
// - Add 0xFFFF+0x0001, cin=0, sub=0 -> 4 cycles later: out_sum=0x0000, cout=1, ovf=0.
// - Subtract 0x8000-0x0001, cin=0, sub=1 -> out_sum=0x7FFF, cout=1, ovf=1.
// - Add 0x7FFF+0x0001 -> out_sum=0x8000, cout=0, ovf=1.
// - Stream 8 random ops back-to-back with out_ready=1:
//   - Results appear on 8 consecutive cycles, in order, matching the reference model.
// - Backpressure: fill the pipe, drop out_ready for 5 cycles.
//   - in_ready=0 and outputs held stable throughout.
//   - Re-assert out_ready -> all results delivered exactly once, in order.
// - Reset mid-stream: 3 ops in flight, rst for 1 cycle -> no out_valid until a new op is issued.

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared defaults and stage-count helper for the pipelined carry-select adder
package csa_pkg;

    localparam int CSA_WIDTH = 16;
    localparam int CSA_BLOCK = 4;

    function automatic int csa_nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csa_block.sv
// rtl/csa_block.sv - one combinational carry-select block: two ripple adders, selected by cin
module csa_block
    import csa_pkg::*;
#(
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [BLOCK:0]   c0;
    logic [BLOCK:0]   c1;
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;

    // Both carry hypotheses ripple in parallel so the late-arriving cin only drives a mux.
    always_comb begin
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        s0    = '0;
        s1    = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (a[i] & c0[i]) | (b[i] & c0[i]);
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (a[i] & c1[i]) | (b[i] & c1[i]);
        end
    end

    assign sum   = cin ? s1 : s0;
    assign cout  = cin ? c1[BLOCK] : c0[BLOCK];
    assign c_msb = cin ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor, one block per stage, global stall
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NBLK = csa_nblk(WIDTH, BLOCK);

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
    end

    logic             adv;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic             ovf_q;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign eff_b    = in_sub ? ~in_b : in_b;
    assign eff_cin  = in_cin ^ in_sub;

    // Stage k resolves bits [k*BLOCK +: BLOCK]; sum_q accumulates all resolved low slices.
    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;

        logic [WIDTH-1:LO]      a_in;
        logic [WIDTH-1:LO]      b_in;
        logic                   cin_in;
        logic                   vld_in;
        logic [BLOCK-1:0]       blk_sum;
        logic                   blk_cout;
        logic                   blk_cmsb;
        logic [LO+BLOCK-1:0]    sum_d;
        logic [LO+BLOCK-1:0]    sum_q;
        logic                   cout_q;
        logic                   vld_q;

        if (k == 0) begin : g_src
            assign a_in   = in_a;
            assign b_in   = eff_b;
            assign cin_in = eff_cin;
            assign vld_in = in_valid;
            assign sum_d  = blk_sum;
        end else begin : g_src
            assign a_in   = g_skew[k-1].a_q;
            assign b_in   = g_skew[k-1].b_q;
            assign cin_in = g_stage[k-1].cout_q;
            assign vld_in = g_stage[k-1].vld_q;
            assign sum_d  = {blk_sum, g_stage[k-1].sum_q};
        end

        if (k != NBLK - 1) begin : g_mid
            logic cmsb_unused;
            assign cmsb_unused = blk_cmsb;
        end

        csa_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a     (a_in[LO +: BLOCK]),
            .b     (b_in[LO +: BLOCK]),
            .cin   (cin_in),
            .sum   (blk_sum),
            .cout  (blk_cout),
            .c_msb (blk_cmsb)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else if (adv) begin
                vld_q  <= vld_in;
                sum_q  <= sum_d;
                cout_q <= blk_cout;
            end
        end
    end

    // Operand bits not yet consumed travel alongside their operation.
    for (genvar k = 0; k < NBLK - 1; k++) begin : g_skew
        localparam int HI_LO = (k + 1) * BLOCK;

        logic [WIDTH-1:HI_LO] a_q;
        logic [WIDTH-1:HI_LO] b_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                a_q <= g_stage[k].a_in[WIDTH-1:HI_LO];
                b_q <= g_stage[k].b_in[WIDTH-1:HI_LO];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[NBLK-1].blk_cmsb ^ g_stage[NBLK-1].blk_cout;
        end
    end

    assign out_valid = g_stage[NBLK-1].vld_q;
    assign out_sum   = g_stage[NBLK-1].sum_q;
    assign out_cout  = g_stage[NBLK-1].cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - randomized scoreboard bench for csa_pipe_adder against an arithmetic model
module tb_csa_pipe_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   out_cycles[$];
    exp_t mon_e;
    exp_t dir_e;
    bit   use_dir = 1'b0;
    bit   chk_lat = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   n_out = 0;

    csa_pipe_adder #(
        .WIDTH (W),
        .BLOCK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned value for sum/carry, signed value for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        int          ua;
        int          ub;
        int          sa;
        int          sb;
        int          total;
        int          sres;
        logic [31:0] t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            total  = ua + ub + int'(cin);
            sres   = sa + sb + int'(cin);
            e.cout = (total >= 65536);
        end else begin
            total  = ua - ub - int'(cin);
            sres   = sa - sb - int'(cin);
            e.cout = (total >= 0);
        end
        t     = total;
        e.sum = t[W-1:0];
        e.ovf = (sres > 32767) || (sres < -32768);
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                out_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sum", out_sum, mon_e.sum);
                    chk("cout", out_cout, mon_e.cout);
                    chk("ovf", out_ovf, mon_e.ovf);
                    if (chk_lat) chk("latency", cyc - mon_e.cyc, 32'd4);
                end
            end
            if (in_valid && in_ready) begin
                mon_e     = use_dir ? dir_e : model(in_a, in_b, in_cin, in_sub);
                mon_e.cyc = cyc;
                exp_q.push_back(mon_e);
            end
        end
    end

    task automatic drive_rand();
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic issue_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic sub, input logic [W-1:0] esum, input logic ecout,
                             input logic eovf);
        dir_e.sum  = esum;
        dir_e.cout = ecout;
        dir_e.ovf  = eovf;
        dir_e.cyc  = 0;
        use_dir    = 1'b1;
        in_a       = a;
        in_b       = b;
        in_cin     = cin;
        in_sub     = sub;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_dir  = 1'b0;
        wait_drain();
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         held_ovf;
        bit           acc;
        int           n0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_cout", out_cout, 32'd0);
        chk("rst_out_ovf", out_ovf, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);

        issue_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue_dir(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // Back-to-back stream
        out_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain();
        chk("stream_count", out_cycles.size(), 32'd8);
        if (out_cycles.size() == 8) chk("stream_consecutive", out_cycles[7] - out_cycles[0], 32'd7);

        // Fill the pipe with the output blocked, then hold for 5 cycles
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        drive_rand();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) drive_rand();
            if (!in_ready) break;
        end
        chk("bp_fill_in_ready", in_ready, 32'd0);
        held_sum  = out_sum;
        held_cout = out_cout;
        held_ovf  = out_ovf;
        n0        = n_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 32'd0);
            chk("bp_out_valid", out_valid, 32'd1);
            chk("bp_sum_stable", out_sum, held_sum);
            chk("bp_cout_stable", out_cout, held_cout);
            chk("bp_ovf_stable", out_ovf, held_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        chk("bp_delivered", n_out - n0, 32'd5);
        chk_lat = 1'b1;

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("midrst_quiet", out_valid, 32'd0);
            @(posedge clk);
            #1;
        end
        drive_rand();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Random valid/ready traffic
        chk_lat = 1'b0;
        drive_rand();
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            acc       = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) drive_rand();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
